// File: rtl/tinker_fetch_pkg.sv
// rtl/tinker_fetch_pkg.sv - shared types and constants for the Tinker fetch queue
package tinker_fetch_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [4:0]  OP_HALT       = 5'h0F;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// rtl/tinker_fetch_fifo.sv - circular buffer of fetch entries with flush
module tinker_fetch_fifo
  import tinker_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != NW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + NW'(1);
      else if (!do_push && do_pop) count <= count - NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/tinker_fetch_queue.sv
// rtl/tinker_fetch_queue.sv - decoupled instruction fetch front end with redirect flush
// Optional FETCH_HALT_STOP_EN stops issuing requests once a halt word is enqueued.
module tinker_fetch_queue
  import tinker_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] PC_RESET = 32'h2000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic                           imem_req_valid,
  input  logic                           imem_req_ready,
  output logic [31:0]                    imem_req_addr,
  input  logic                           imem_rsp_valid,
  input  logic [31:0]                    imem_rsp_data,
  output logic                           dec_valid,
  input  logic                           dec_ready,
  output logic [31:0]                    dec_inst,
  output logic [31:0]                    dec_pc,
  output logic [$clog2(MAX_OUT+1)-1:0]   inflight
);

  localparam int CW = $clog2(MAX_OUT+1);
  localparam int NW = $clog2(DEPTH+1);
  localparam int SW = ((NW > CW) ? NW : CW) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   exp_pc;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] live;
  logic [NW-1:0] fifo_count;
  logic [SW-1:0] occupancy;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic          halt_block;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Responses still owed to the FIFO reserve a slot, so occupancy never exceeds DEPTH.
  assign live      = inflight - drop_cnt;
  assign occupancy = SW'(fifo_count) + SW'(live);

  assign imem_req_valid = !reset && !redirect_valid && !halt_block &&
                          (inflight < CW'(MAX_OUT)) && (occupancy < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign push_entry = '{inst: imem_rsp_data, pc: exp_pc};

  assign dec_valid = (fifo_count != '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign dec_inst  = (fifo_count != '0) ? head.inst : '0;
  assign dec_pc    = (fifo_count != '0) ? head.pc   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      drop_cnt <= '0;
      fetch_pc <= PC_RESET;
      exp_pc   <= PC_RESET;
    end else begin
      if (req_fire && !imem_rsp_valid)      inflight <= inflight + CW'(1);
      else if (!req_fire && imem_rsp_valid) inflight <= inflight - CW'(1);

      if (redirect_valid) begin
        // Everything still outstanding after this cycle's response is stale.
        drop_cnt <= imem_rsp_valid ? (inflight - CW'(1)) : inflight;
        fetch_pc <= align_pc(redirect_pc);
        exp_pc   <= align_pc(redirect_pc);
      end else begin
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) exp_pc   <= exp_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_HALT_STOP_EN
  logic halt_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  halt_seen <= 1'b0;
    else if (redirect_valid)                                    halt_seen <= 1'b0;
    else if (rsp_keep && (imem_rsp_data[31:27] == OP_HALT))     halt_seen <= 1'b1;
  end

  assign halt_block = halt_seen;
`else
  assign halt_block = 1'b0;
`endif

  tinker_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// tb/tb_tinker_fetch_queue.sv - directed and randomized checks for tinker_fetch_queue
module tb_tinker_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] PC_RESET = 32'h2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [1:0]  inflight;

  always #5 clk = ~clk;

  tinker_fetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .PC_RESET (PC_RESET)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .inflight       (inflight)
  );

  typedef struct {
    logic        dr;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_dv;
    logic [31:0] exp_pc;
    int          exp_inf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          n_pops = 0;
  int          ovf = 0;
  int          lat_v = 1;
  logic        rst_v = 1'b1;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc_v = '0;
  logic        dr_v = 1'b1;
  logic        rand_ready = 1'b0;
  logic        rand_lat = 1'b0;
  logic        rand_dr = 1'b0;
  logic        rand_redir = 1'b0;
  logic [31:0] model_pc = PC_RESET;
  logic [31:0] max_req = '0;
  logic [31:0] halt_addr = 32'hFFFF_FFFF;
  rsp_t        pend[$];
  vec_t        tbl[16];

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == halt_addr) return 32'h7800_0000;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t v(input logic dr, input logic rv, input logic [31:0] addr,
                             input logic dv, input logic [31:0] pc, input int inf);
    vec_t r;
    r.dr = dr; r.exp_rv = rv; r.exp_addr = addr; r.exp_dv = dv; r.exp_pc = pc; r.exp_inf = inf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, sample settled outputs 1ns later, model memory and decode.
  task automatic step();
    int l;
    int due;
    logic rr;
    @(negedge clk);
    reset = rst_v;
    if (rand_redir && !rst_v && ($urandom_range(0, 49) == 0)) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2000 + 32'($urandom_range(0, 4095));
    end else begin
      redirect_valid = redir_v;
      redirect_pc    = redir_pc_v;
    end
    dec_ready      = rand_dr ? ($urandom_range(0, 1) == 1) : dr_v;
    rr             = ($urandom_range(0, 1) == 1);
    imem_req_ready = rand_ready ? rr : 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_v) begin
      pend.delete();
      last_due = 0;
      model_pc = PC_RESET;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
    end
    if (redirect_valid) model_pc = redirect_pc & 32'hFFFF_FFFC;
    #1;
    if (!rst_v) begin
      if (inflight > 2'(MAX_OUT)) ovf++;
      if (imem_rsp_valid && !redirect_valid && dut.drop_cnt == '0 &&
          dut.fifo_count == 3'(DEPTH) && !(dec_valid && dec_ready)) ovf++;
    end
    if (imem_req_valid && imem_req_ready) begin
      l   = rand_lat ? int'($urandom_range(1, 4)) : lat_v;
      due = cyc + l;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{data: word(imem_req_addr), due: due});
      if (imem_req_addr > max_req) max_req = imem_req_addr;
    end
    if (dec_valid && dec_ready) begin
      chk("stream_pc", dec_pc, model_pc);
      chk("stream_inst", dec_inst, word(dec_pc));
      model_pc = model_pc + 32'd4;
      n_pops++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    redir_v = 1'b0;
    step();
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_inst", dec_inst, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_inflight", 32'(inflight), 0);
    rst_v = 1'b0;
    cyc = 0;
  endtask

  initial begin
    tbl[0]  = v(1, 1, 32'h2000, 0, 32'h0,    0);
    tbl[1]  = v(1, 1, 32'h2004, 0, 32'h0,    1);
    tbl[2]  = v(1, 1, 32'h2008, 1, 32'h2000, 1);
    tbl[3]  = v(1, 1, 32'h200C, 1, 32'h2004, 1);
    tbl[4]  = v(1, 1, 32'h2010, 1, 32'h2008, 1);
    tbl[5]  = v(1, 1, 32'h2014, 1, 32'h200C, 1);
    tbl[6]  = v(0, 1, 32'h2018, 1, 32'h2010, 1);
    tbl[7]  = v(0, 1, 32'h201C, 1, 32'h2010, 1);
    tbl[8]  = v(0, 0, 32'h0,    1, 32'h2010, 1);
    tbl[9]  = v(0, 0, 32'h0,    1, 32'h2010, 0);
    tbl[10] = v(0, 0, 32'h0,    1, 32'h2010, 0);
    tbl[11] = v(1, 0, 32'h0,    1, 32'h2010, 0);
    tbl[12] = v(1, 1, 32'h2020, 1, 32'h2014, 0);
    tbl[13] = v(1, 1, 32'h2024, 1, 32'h2018, 1);
    tbl[14] = v(1, 1, 32'h2028, 1, 32'h201C, 1);
    tbl[15] = v(1, 1, 32'h202C, 1, 32'h2020, 1);

    // Zero-wait memory: streaming, then decode stall filling the FIFO, then release.
    do_reset();
    lat_v = 1;
    for (int i = 0; i < 16; i++) begin
      dr_v = tbl[i].dr;
      step();
      chk($sformatf("t%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].exp_dv));
      if (tbl[i].exp_dv) begin
        chk($sformatf("t%0d_dec_pc", i), dec_pc, tbl[i].exp_pc);
        chk($sformatf("t%0d_dec_inst", i), dec_inst, word(tbl[i].exp_pc));
      end
      chk($sformatf("t%0d_inflight", i), 32'(inflight), 32'(tbl[i].exp_inf));
      if (i == 9) chk("t9_fifo_full", 32'(dut.fifo_count), DEPTH);
    end

    // Redirect with two requests in flight at 3-cycle latency.
    do_reset();
    lat_v = 3;
    dr_v  = 1'b1;
    step();
    step();
    redir_v = 1'b1; redir_pc_v = 32'h3002;
    step();
    chk("rd_req_valid", 32'(imem_req_valid), 0);
    chk("rd_dec_valid", 32'(dec_valid), 0);
    chk("rd_inflight", 32'(inflight), 2);
    redir_v = 1'b0;
    step();
    chk("rd_drop2", 32'(dut.drop_cnt), 2);
    chk("rd_req_blocked", 32'(imem_req_valid), 0);
    step();
    chk("rd_drop1", 32'(dut.drop_cnt), 1);
    chk("rd_req_valid_new", 32'(imem_req_valid), 1);
    chk("rd_req_addr_new", imem_req_addr, 32'h3000);
    step();
    chk("rd_drop0", 32'(dut.drop_cnt), 0);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        if (dec_valid) begin
          found = 1'b1;
          chk("rd_first_pc", dec_pc, 32'h3000);
          chk("rd_first_inst", dec_inst, word(32'h3000));
        end
      end
      chk("rd_first_seen", 32'(found), 1);
    end

    // Redirect coinciding with a response into a nearly full FIFO.
    do_reset();
    lat_v = 1;
    dr_v  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    redir_v = 1'b1; redir_pc_v = 32'h4001;
    step();
    chk("rf_count_before", 32'(dut.fifo_count), 3);
    chk("rf_rsp_present", 32'(imem_rsp_valid), 1);
    chk("rf_req_valid", 32'(imem_req_valid), 0);
    chk("rf_dec_valid", 32'(dec_valid), 0);
    redir_v = 1'b0;
    dr_v    = 1'b1;
    step();
    chk("rf_count_after", 32'(dut.fifo_count), 0);
    chk("rf_inflight", 32'(inflight), 0);
    chk("rf_drop", 32'(dut.drop_cnt), 0);
    chk("rf_req_addr", imem_req_addr, 32'h4000);
    chk("rf_req_valid2", 32'(imem_req_valid), 1);
    step();
    chk("rf_dec_valid_r2", 32'(dec_valid), 0);
    step();
    chk("rf_dec_valid_r3", 32'(dec_valid), 1);
    chk("rf_dec_pc_r3", dec_pc, 32'h4000);

    // Random ready, latency, decode stalls and occasional redirects.
    do_reset();
    rand_ready = 1'b1; rand_lat = 1'b1; rand_dr = 1'b1; rand_redir = 1'b1;
    n_pops = 0;
    ovf    = 0;
    for (int i = 0; i < 30000 && n_pops < 1000; i++) step();
    chk("rand_pops_reached", 32'(n_pops >= 1000), 1);
    chk("rand_no_overflow", 32'(ovf), 0);
    rand_ready = 1'b0; rand_lat = 1'b0; rand_dr = 1'b0; rand_redir = 1'b0;

`ifdef FETCH_HALT_STOP_EN
    do_reset();
    halt_addr = 32'h2008;
    lat_v = 1;
    dr_v  = 1'b1;
    max_req = '0;
    for (int i = 0; i < 12; i++) step();
    chk("halt_max_req", max_req, 32'h200C);
    chk("halt_req_valid", 32'(imem_req_valid), 0);
    redir_v = 1'b1; redir_pc_v = 32'h2100;
    step();
    redir_v = 1'b0;
    step();
    chk("halt_resume_valid", 32'(imem_req_valid), 1);
    chk("halt_resume_addr", imem_req_addr, 32'h2100);
    halt_addr = 32'hFFFF_FFFF;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
